lcd_timing: RTL and testbench
=============================

LCD_TIMING -- requirements
Module: lcd_timing

Interface
REQ-001 Parameter H_ACTIVE, 480: visible pixels per line.
REQ-002 Parameter H_FP, 8: horizontal front porch in dclk periods.
REQ-003 Parameter H_SYNC, 4: hsync pulse width in dclk periods.
REQ-004 Parameter H_BP, 43: horizontal back porch in dclk periods.
REQ-005 Parameter V_ACTIVE, 272: visible lines per frame.
REQ-006 Parameter V_FP, 8: vertical front porch in lines.
REQ-007 Parameter V_SYNC, 4: vsync pulse width in lines.
REQ-008 Parameter V_BP, 12: vertical back porch in lines.
REQ-009 Parameter DCLK_DIV, 8: clk cycles per lcd_dclk period; even, at least 2.
REQ-010 clk  input  1  system clock; sole clock of the block.
REQ-011 rst_n  input  1  asynchronous, active-low reset.
REQ-012 lcd_dclk  output  1  panel pixel clock.
REQ-013 lcd_hsync  output  1  horizontal sync, active low.
REQ-014 lcd_vsync  output  1  vertical sync, active low.
REQ-015 lcd_de  output  1  data enable, high in the active area.
REQ-016 pos_x  output  10  active-area column for the downstream pixel generator.
REQ-017 pos_y  output  9  active-area row for the downstream pixel generator.
REQ-018 frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-019 The block SHALL keep a divider counter div_cnt that counts 0..DCLK_DIV-1 on every clk and wraps to 0.
REQ-020 lcd_dclk SHALL be registered: low while div_cnt < DCLK_DIV/2, high otherwise, giving a 50% duty cycle.
REQ-021 h_cnt (0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) SHALL advance only on the clk where div_cnt wraps to 0, i.e. the lcd_dclk falling edge.
REQ-022 v_cnt (0..V_TOTAL-1, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP) SHALL increment when h_cnt wraps from H_TOTAL-1 to 0.
REQ-023 v_cnt SHALL wrap to 0 after V_TOTAL-1.
REQ-024 Line order SHALL be: active [0, H_ACTIVE), front porch, sync, back porch. The vertical order SHALL be the same.
REQ-025 lcd_hsync SHALL be 0 exactly for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and 1 otherwise.
REQ-026 lcd_vsync SHALL follow the same rule using the V parameters and v_cnt.
REQ-027 lcd_de SHALL be 1 exactly when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-028 When lcd_de is 1, pos_x SHALL equal h_cnt and pos_y SHALL equal v_cnt.
REQ-029 When lcd_de is 0, pos_x and pos_y SHALL be 0.
REQ-030 lcd_hsync, lcd_vsync, lcd_de, pos_x and pos_y SHALL all be registered and SHALL change together on the dclk-falling clk.
REQ-031 Those outputs SHALL hold stable for DCLK_DIV clk cycles, so downstream logic with up to DCLK_DIV/2 clk latency is valid at the next lcd_dclk rising edge.
REQ-032 frame_start SHALL be 1 for exactly one clk, on the clk where h_cnt and v_cnt both become 0.
REQ-033 Counter arithmetic SHALL be unsigned and sized so that H_TOTAL-1 and V_TOTAL-1 are representable without overflow.

Reset
REQ-034 While rst_n=0, the block SHALL hold div_cnt=0, h_cnt=0, v_cnt=0, lcd_dclk=0, lcd_hsync=1, lcd_vsync=1, lcd_de=0, pos_x=0, pos_y=0, frame_start=0.
REQ-035 Reset assertion at any point mid-frame SHALL take effect immediately, without waiting for a clk edge.
REQ-036 After rst_n deasserts, the first dclk falling edge SHALL occur DCLK_DIV clk cycles later.
REQ-037 That first falling edge SHALL present pixel (0,0) with lcd_de=1 and frame_start=1.

Configuration
REQ-038 With macro FRAME_COUNTER_EN defined, the block SHALL add output frame_cnt [7:0].
REQ-039 frame_cnt SHALL reset to 0, increment by 1 on every frame_start pulse, and wrap from 255 to 0.
REQ-040 Without FRAME_COUNTER_EN, the port and its logic SHALL be absent. All other behaviour SHALL be identical with or without the macro.

Verification
REQ-041 H=4/1/1/1, V=2/1/1/1, DCLK_DIV=4, release reset -> lcd_dclk period 4 clk; first de=1 with pos=(0,0); frame_start pulses every 7*5*4=140 clk.
REQ-042 Same parameters, check over one line -> lcd_de high for 4 dclk; hsync low only at h_cnt=5; pos_x sequence 0,1,2,3,0,0,0.
REQ-043 Same parameters, check over one frame -> vsync low only for v_cnt=3 (7 dclk); pos_y=0 whenever de=0.
REQ-044 Default parameters, DCLK_DIV=8 -> H_TOTAL=535, V_TOTAL=296; frame_start interval 535*296*8=1266880 clk.
REQ-045 Assert rst_n low at h_cnt=2, v_cnt=1 -> all outputs reach reset values with no clk edge; restart from (0,0) after release.
REQ-046 FRAME_COUNTER_EN defined, run 257 frames -> frame_cnt reads 1 after the 257th frame_start (wrapped).

Source files
------------

// File: rtl/lcd_if.sv
// Panel-side signal bundle for lcd_timing; master drives, slave consumes.
// frame_cnt is present only when FRAME_COUNTER_EN is defined.
interface lcd_if;
    logic       lcd_dclk;
    logic       lcd_hsync;
    logic       lcd_vsync;
    logic       lcd_de;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       frame_start;
`ifdef FRAME_COUNTER_EN
    logic [7:0] frame_cnt;

    modport master (
        output lcd_dclk, lcd_hsync, lcd_vsync, lcd_de, pos_x, pos_y, frame_start, frame_cnt
    );
    modport slave (
        input lcd_dclk, lcd_hsync, lcd_vsync, lcd_de, pos_x, pos_y, frame_start, frame_cnt
    );
`else
    modport master (
        output lcd_dclk, lcd_hsync, lcd_vsync, lcd_de, pos_x, pos_y, frame_start
    );
    modport slave (
        input lcd_dclk, lcd_hsync, lcd_vsync, lcd_de, pos_x, pos_y, frame_start
    );
`endif
endinterface

// File: rtl/lcd_timing.sv
// RGB LCD panel timing generator: divided pixel clock, sync, data enable and pixel position.
// Optional FRAME_COUNTER_EN adds an 8-bit wrapping frame counter.
module lcd_timing #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 8,
    parameter int unsigned H_SYNC   = 4,
    parameter int unsigned H_BP     = 43,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 8,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 12,
    parameter int unsigned DCLK_DIV = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    lcd_if.master lcd
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);
    localparam int unsigned DW      = $clog2(DCLK_DIV);

    localparam logic [DW-1:0] DivLast   = DW'(DCLK_DIV - 1);
    localparam logic [DW-1:0] DivHalf   = DW'(DCLK_DIV / 2);
    localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActEnd   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HSyncBeg  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HSyncEnd  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActEnd   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VSyncBeg  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VSyncEnd  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          run_q, run_d;
    logic          dclk_q, dclk_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [8:0]    pos_y_q, pos_y_d;
    logic          fs_q, fs_d;
    logic          wrap;

    always_comb begin
        wrap    = (div_q == DivLast);
        div_d   = wrap ? '0 : div_q + DW'(1);
        dclk_d  = (div_d >= DivHalf);
        h_d     = h_q;
        v_d     = v_q;
        run_d   = run_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        fs_d    = 1'b0;
        if (wrap) begin
            run_d = 1'b1;
            // The first falling edge after reset presents (0,0) instead of advancing.
            if (run_q) begin
                if (h_q == HLast) begin
                    h_d = '0;
                    v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            hsync_d = !((h_d >= HSyncBeg) && (h_d < HSyncEnd));
            vsync_d = !((v_d >= VSyncBeg) && (v_d < VSyncEnd));
            de_d    = (h_d < HActEnd) && (v_d < VActEnd);
            pos_x_d = de_d ? 10'(h_d) : '0;
            pos_y_d = de_d ? 9'(v_d) : '0;
            fs_d    = (h_d == '0) && (v_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            run_q   <= 1'b0;
            dclk_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            run_q   <= run_d;
            dclk_q  <= dclk_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            fs_q    <= fs_d;
        end
    end

    assign lcd.lcd_dclk    = dclk_q;
    assign lcd.lcd_hsync   = hsync_q;
    assign lcd.lcd_vsync   = vsync_q;
    assign lcd.lcd_de      = de_q;
    assign lcd.pos_x       = pos_x_q;
    assign lcd.pos_y       = pos_y_q;
    assign lcd.frame_start = fs_q;

`ifdef FRAME_COUNTER_EN
    logic [7:0] fcnt_q, fcnt_d;

    assign fcnt_d = fcnt_q + 8'(fs_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign lcd.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_lcd_timing.sv
// Scoreboarded bench for lcd_timing with a small panel geometry and random reset/run segments.
module tb_lcd_timing;
    localparam int HA = 4, HFP = 1, HS = 1, HBP = 1;
    localparam int VA = 2, VFP = 1, VS = 1, VBP = 1;
    localparam int D  = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    typedef struct packed {
        logic       dclk;
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [9:0] px;
        logic [8:0] py;
        logic       fs;
        logic [7:0] fcnt;
    } vec_t;

    logic clk;
    logic rst_n;
    lcd_if lcd_bus ();

    lcd_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .DCLK_DIV(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lcd  (lcd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t reset_vec();
        vec_t r;
        r       = '0;
        r.hsync = 1'b1;
        r.vsync = 1'b1;
        return r;
    endfunction

    // Expected outputs t clk edges after reset release, from the panel timing rules.
    function automatic vec_t model(int t);
        vec_t r;
        int   k, h, v, div;
        r      = reset_vec();
        div    = t % D;
        r.dclk = (div >= D / 2);
        if (t < D) return r;
        k       = t / D - 1;
        h       = k % HT;
        v       = (k / HT) % VT;
        r.hsync = !(h >= HA + HFP && h < HA + HFP + HS);
        r.vsync = !(v >= VA + VFP && v < VA + VFP + VS);
        r.de    = (h < HA) && (v < VA);
        r.px    = r.de ? 10'(h) : 10'd0;
        r.py    = r.de ? 9'(v) : 9'd0;
        r.fs    = (div == 0) && (h == 0) && (v == 0);
`ifdef FRAME_COUNTER_EN
        r.fcnt  = 8'((k / (HT * VT) + 1) % 256);
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        vec_t act, e;
        if (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            act.dclk  = lcd_bus.lcd_dclk;
            act.hsync = lcd_bus.lcd_hsync;
            act.vsync = lcd_bus.lcd_vsync;
            act.de    = lcd_bus.lcd_de;
            act.px    = lcd_bus.pos_x;
            act.py    = lcd_bus.pos_y;
            act.fs    = lcd_bus.frame_start;
`ifdef FRAME_COUNTER_EN
            act.fcnt  = lcd_bus.frame_cnt;
`else
            act.fcnt  = 8'd0;
`endif
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL out_vec[%0d] t=%0t actual=%h required=%h", n_vec, $time, act, e);
            end
        end
    end

    task automatic hold_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            exp_q.push_back(reset_vec());
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic run(int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            exp_q.push_back(model(i));
        end
    endtask

    // Reset lands between clock edges; outputs must already be at reset values on the next negedge.
    task automatic assert_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.push_back(reset_vec());
    endtask

    initial begin
        rst_n = 1'b0;
        hold_reset(3);
        run(300);
        assert_reset();
        hold_reset(int'($urandom_range(1, 4)));
        run((HT * 1 + 2 + 1) * D + 1);
        assert_reset();
        for (int s = 0; s < 3; s++) begin
            hold_reset(int'($urandom_range(1, 4)));
            run(int'($urandom_range(20, 600)));
            assert_reset();
        end
        hold_reset(2);
        run(257 * HT * VT * D + 20);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
